// File: rtl/rename_stage_pkg.sv
// Shared RV32I pipeline types used by rename/dispatch.
// Physical-register and ROB-id fields are sized for the largest configuration.
package rv32i_types;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1_s;
        logic [4:0]  rs2_s;
        logic [4:0]  rd_s;
        logic        rs1_needed;
        logic        rs2_needed;
    } instruction_info_reg_t;

    typedef struct packed {
        logic       dependency;
        logic [7:0] rob_id;
    } physical_reg_data_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc_rdata;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [31:0] rd_wdata;
    } rvfi_t;

    typedef struct packed {
        rvfi_t      rvfi;
        logic [7:0] rs1_paddr;
        logic [7:0] rs2_paddr;
        logic [7:0] rd_paddr;
        logic [7:0] rob_id;
        logic [7:0] rs1_rob;
        logic [7:0] rs2_rob;
        logic       input1_met;
        logic       input2_met;
    } dispatch_reservation_t;

endpackage

// File: rtl/rename_stage_prefix_alloc.sv
// Exclusive prefix count over a slot mask: idx_o[i] is the number of set
// bits below slot i, count_o the total.
module prefix_alloc #(
    parameter  int unsigned SS = 2,
    localparam int unsigned CW = $clog2(SS) + 1
) (
    input  logic [SS-1:0]         mask_i,
    output logic [SS-1:0][CW-1:0] idx_o,
    output logic [CW-1:0]         count_o
);

    always_comb begin
        logic [CW-1:0] acc;
        acc   = '0;
        idx_o = '0;
        for (int unsigned i = 0; i < SS; i++) begin
            idx_o[i] = acc;
            if (mask_i[i]) acc = acc + CW'(1);
        end
        count_o = acc;
    end

endmodule

// File: rtl/rename_stage.sv
// Rename stage: holds one decoded bundle, allocates physical registers and
// ROB ids, resolves intra-bundle dependencies and dispatches to RS/ROB.
module rename_stage
    import rv32i_types::*;
#(
    parameter  int unsigned SS         = 2,
    parameter  int unsigned PR_ENTRIES = 64,
    parameter  int unsigned ROB_DEPTH  = 16,
    localparam int unsigned PRW        = $clog2(PR_ENTRIES),
    localparam int unsigned ROBW       = $clog2(ROB_DEPTH),
    localparam int unsigned CW         = $clog2(SS) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  instruction_info_reg_t [SS-1:0]  in_inst,
    output logic [SS-1:0][4:0]              isa_rs1,
    output logic [SS-1:0][4:0]              isa_rs2,
    output logic [SS-1:0][4:0]              isa_rd,
    input  logic [SS-1:0][PRW-1:0]          rat_rs1,
    input  logic [SS-1:0][PRW-1:0]          rat_rs2,
    output logic [SS-1:0]                   rat_we,
    output logic [SS-1:0][PRW-1:0]          rat_dest,
    input  logic [PRW:0]                    fl_avail,
    input  logic [SS-1:0][PRW-1:0]          fl_regs,
    output logic [CW-1:0]                   fl_pop,
    input  physical_reg_data_t [SS-1:0]     pr_rs1,
    input  physical_reg_data_t [SS-1:0]     pr_rs2,
    input  logic [ROBW:0]                   rob_space,
    input  logic [SS-1:0][ROBW-1:0]         rob_id_next,
    input  logic [CW-1:0]                   rs_space,
    output logic                            dispatch,
    output dispatch_reservation_t [SS-1:0]  rs_entries,
    output logic [31:0]                     stall_cycles
);

    localparam int unsigned IW = (SS > 1) ? $clog2(SS) : 1;

    logic                           hold_valid_q, hold_valid_d;
    instruction_info_reg_t [SS-1:0] hold_inst_q,  hold_inst_d;
    logic [31:0]                    stall_q,      stall_d;

    logic [SS-1:0]          val_mask, dst_mask;
    logic [SS-1:0][CW-1:0]  dst_idx, rob_idx;
    logic [CW-1:0]          n_dst, n_val;
    logic [SS-1:0][PRW-1:0] new_pr;
    logic [SS-1:0][ROBW-1:0] new_rob;

    always_comb begin
        val_mask = '0;
        dst_mask = '0;
        for (int unsigned i = 0; i < SS; i++) begin
            val_mask[i] = hold_inst_q[i].valid;
            dst_mask[i] = hold_inst_q[i].valid && (hold_inst_q[i].rd_s != 5'd0);
        end
    end

    prefix_alloc #(.SS(SS)) u_dst_alloc (.mask_i(dst_mask), .idx_o(dst_idx), .count_o(n_dst));
    prefix_alloc #(.SS(SS)) u_rob_alloc (.mask_i(val_mask), .idx_o(rob_idx), .count_o(n_val));

    assign dispatch = hold_valid_q && !flush
                   && (32'(fl_avail)  >= 32'(n_dst))
                   && (32'(rob_space) >= 32'(n_val))
                   && (32'(rs_space)  >= 32'(n_val));
    assign in_ready     = (!hold_valid_q || dispatch) && !flush;
    assign fl_pop       = dispatch ? n_dst : '0;
    assign stall_cycles = stall_q;

    always_comb begin
        isa_rs1    = '0;
        isa_rs2    = '0;
        isa_rd     = '0;
        rat_we     = '0;
        rat_dest   = '0;
        new_pr     = '0;
        new_rob    = '0;
        rs_entries = '0;
        for (int unsigned i = 0; i < SS; i++) begin
            new_pr[i]  = fl_regs[IW'(dst_idx[i])];
            new_rob[i] = rob_id_next[IW'(rob_idx[i])];
        end
        for (int unsigned j = 0; j < SS; j++) begin
            logic          b1, b2;
            logic [IW-1:0] s1, s2;
            b1 = 1'b0;
            b2 = 1'b0;
            s1 = '0;
            s2 = '0;
            // Ascending scan: the last match is the youngest earlier writer.
            for (int unsigned k = 0; k < j; k++) begin
                if (dst_mask[k] && hold_inst_q[k].rd_s == hold_inst_q[j].rs1_s) begin
                    b1 = 1'b1;
                    s1 = IW'(k);
                end
                if (dst_mask[k] && hold_inst_q[k].rd_s == hold_inst_q[j].rs2_s) begin
                    b2 = 1'b1;
                    s2 = IW'(k);
                end
            end
            isa_rs1[j]  = hold_inst_q[j].rs1_s;
            isa_rs2[j]  = hold_inst_q[j].rs2_s;
            isa_rd[j]   = dst_mask[j] ? hold_inst_q[j].rd_s : 5'd0;
            rat_we[j]   = dispatch && dst_mask[j];
            rat_dest[j] = dst_mask[j] ? new_pr[j] : '0;

            rs_entries[j].rvfi.valid    = hold_inst_q[j].valid && dispatch;
            rs_entries[j].rvfi.pc_rdata = hold_inst_q[j].pc;
            rs_entries[j].rvfi.inst     = hold_inst_q[j].inst;
            rs_entries[j].rvfi.rs1_addr = hold_inst_q[j].rs1_s;
            rs_entries[j].rvfi.rs2_addr = hold_inst_q[j].rs2_s;
            rs_entries[j].rvfi.rd_addr  = hold_inst_q[j].rd_s;
            rs_entries[j].rd_paddr      = 8'(rat_dest[j]);
            rs_entries[j].rob_id        = 8'(new_rob[j]);
            rs_entries[j].rs1_paddr     = b1 ? 8'(new_pr[s1])  : 8'(rat_rs1[j]);
            rs_entries[j].rs1_rob       = b1 ? 8'(new_rob[s1]) : pr_rs1[j].rob_id;
            rs_entries[j].rs2_paddr     = b2 ? 8'(new_pr[s2])  : 8'(rat_rs2[j]);
            rs_entries[j].rs2_rob       = b2 ? 8'(new_rob[s2]) : pr_rs2[j].rob_id;
            rs_entries[j].input1_met    = !hold_inst_q[j].rs1_needed || hold_inst_q[j].rs1_s == 5'd0
                                          || (!b1 && !pr_rs1[j].dependency);
            rs_entries[j].input2_met    = !hold_inst_q[j].rs2_needed || hold_inst_q[j].rs2_s == 5'd0
                                          || (!b2 && !pr_rs2[j].dependency);
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_inst_d  = hold_inst_q;
        stall_d      = stall_q;
        if (flush) begin
            hold_valid_d = 1'b0;
        end else if (in_valid && in_ready) begin
            hold_valid_d = 1'b1;
            hold_inst_d  = in_inst;
        end else if (dispatch) begin
            hold_valid_d = 1'b0;
        end
        if (hold_valid_q && !dispatch && !flush && stall_q != '1) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            stall_q      <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            stall_q      <= stall_d;
        end
        hold_inst_q <= hold_inst_d;
    end

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage (4-wide configuration).
module tb_rename_stage;
    import rv32i_types::*;

    logic                          clk = 1'b0;
    logic                          rst, flush, in_valid, in_ready, dispatch;
    instruction_info_reg_t [3:0]   in_inst;
    logic [3:0][4:0]               isa_rs1, isa_rs2, isa_rd;
    logic [3:0][5:0]               rat_rs1, rat_rs2, rat_dest, fl_regs;
    logic [3:0]                    rat_we;
    logic [6:0]                    fl_avail;
    logic [2:0]                    fl_pop, rs_space;
    physical_reg_data_t [3:0]      pr_rs1, pr_rs2;
    logic [4:0]                    rob_space;
    logic [3:0][3:0]               rob_id_next;
    dispatch_reservation_t [3:0]   rs_entries;
    logic [31:0]                   stall_cycles;

    int total = 0;
    int bad   = 0;

    rename_stage #(.SS(4), .PR_ENTRIES(64), .ROB_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .isa_rs1(isa_rs1), .isa_rs2(isa_rs2), .isa_rd(isa_rd),
        .rat_rs1(rat_rs1), .rat_rs2(rat_rs2), .rat_we(rat_we), .rat_dest(rat_dest),
        .fl_avail(fl_avail), .fl_regs(fl_regs), .fl_pop(fl_pop),
        .pr_rs1(pr_rs1), .pr_rs2(pr_rs2), .rob_space(rob_space), .rob_id_next(rob_id_next),
        .rs_space(rs_space), .dispatch(dispatch), .rs_entries(rs_entries),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instruction_info_reg_t mk(input logic [4:0] a, input logic [4:0] b,
                                                 input logic [4:0] d, input logic n1,
                                                 input logic n2, input logic [31:0] pc);
        instruction_info_reg_t r;
        r            = '0;
        r.valid      = 1'b1;
        r.pc         = pc;
        r.inst       = {12'h0, a, b, d, 5'h0};
        r.rs1_s      = a;
        r.rs2_s      = b;
        r.rd_s       = d;
        r.rs1_needed = n1;
        r.rs2_needed = n2;
        return r;
    endfunction

    task automatic load(input instruction_info_reg_t s0, input instruction_info_reg_t s1,
                        input instruction_info_reg_t s2, input instruction_info_reg_t s3);
        in_inst[0] = s0;
        in_inst[1] = s1;
        in_inst[2] = s2;
        in_inst[3] = s3;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0;
        fl_avail = 7'd64; rob_space = 5'd16; rs_space = 3'd4;
        for (int i = 0; i < 4; i++) begin
            rat_rs1[i]     = 6'(10 + i);
            rat_rs2[i]     = 6'(20 + i);
            pr_rs1[i]      = '{dependency: 1'b0, rob_id: 8'(8'h70 + i)};
            pr_rs2[i]      = '{dependency: 1'b0, rob_id: 8'(8'h80 + i)};
            fl_regs[i]     = 6'(40 + i);
            rob_id_next[i] = 4'(8 + i);
        end
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_dispatch", 64'(dispatch), 64'd0);
        chk("rst_fl_pop", 64'(fl_pop), 64'd0);
        chk("rst_rat_we", 64'(rat_we), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);

        // add x5,x1,x2 ; add x6,x5,x5
        load(mk(5'd1, 5'd2, 5'd5, 1'b1, 1'b1, 32'h100), mk(5'd5, 5'd5, 5'd6, 1'b1, 1'b1, 32'h104), '0, '0);
        chk("byp_dispatch", 64'(dispatch), 64'd1);
        chk("byp_fl_pop", 64'(fl_pop), 64'd2);
        chk("byp_dest0", 64'(rat_dest[0]), 64'd40);
        chk("byp_dest1", 64'(rat_dest[1]), 64'd41);
        chk("byp_rat_we", 64'(rat_we), 64'b0011);
        chk("byp_s1_rs1", 64'(rs_entries[1].rs1_paddr), 64'd40);
        chk("byp_s1_rs2", 64'(rs_entries[1].rs2_paddr), 64'd40);
        chk("byp_s1_met1", 64'(rs_entries[1].input1_met), 64'd0);
        chk("byp_s1_met2", 64'(rs_entries[1].input2_met), 64'd0);
        chk("byp_s1_rob1", 64'(rs_entries[1].rs1_rob), 64'd8);
        chk("byp_s1_robid", 64'(rs_entries[1].rob_id), 64'd9);
        chk("byp_s0_rs1", 64'(rs_entries[0].rs1_paddr), 64'd10);
        chk("byp_s0_met1", 64'(rs_entries[0].input1_met), 64'd1);
        chk("byp_s0_pc", 64'(rs_entries[0].rvfi.pc_rdata), 64'h100);
        chk("byp_s2_valid", 64'(rs_entries[2].rvfi.valid), 64'd0);
        chk("byp_in_ready", 64'(in_ready), 64'd1);
        tick();

        // sw x3,0(x2) ; addi x7,x1,imm
        for (int i = 0; i < 4; i++) fl_regs[i] = 6'(33 + i);
        pr_rs1[0].dependency = 1'b1;
        pr_rs2[1].dependency = 1'b1;
        load(mk(5'd2, 5'd3, 5'd0, 1'b1, 1'b1, 32'h200), mk(5'd1, 5'd0, 5'd7, 1'b1, 1'b0, 32'h204), '0, '0);
        chk("sw_dest1", 64'(rat_dest[1]), 64'd33);
        chk("sw_dest0", 64'(rat_dest[0]), 64'd0);
        chk("sw_rat_we", 64'(rat_we), 64'b0010);
        chk("sw_fl_pop", 64'(fl_pop), 64'd1);
        chk("sw_s0_met1", 64'(rs_entries[0].input1_met), 64'd0);
        chk("sw_s1_met2", 64'(rs_entries[1].input2_met), 64'd1);
        chk("sw_s1_robid", 64'(rs_entries[1].rob_id), 64'd9);
        chk("sw_s1_rs1", 64'(rs_entries[1].rs1_paddr), 64'd11);
        chk("sw_s1_rob1", 64'(rs_entries[1].rs1_rob), 64'h71);
        tick();
        pr_rs1[0].dependency = 1'b0;
        pr_rs2[1].dependency = 1'b0;

        // free-list starvation for three cycles
        fl_avail = 7'd1;
        load(mk(5'd1, 5'd2, 5'd8, 1'b1, 1'b1, 32'h300), mk(5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 32'h304), '0, '0);
        for (int c = 0; c < 3; c++) begin
            chk("stv_dispatch", 64'(dispatch), 64'd0);
            chk("stv_in_ready", 64'(in_ready), 64'd0);
            chk("stv_fl_pop", 64'(fl_pop), 64'd0);
            chk("stv_rat_we", 64'(rat_we), 64'd0);
            tick();
            #1;
        end
        fl_avail = 7'd2;
        #1;
        chk("stv_stall", 64'(stall_cycles), 64'd3);
        chk("stv_release", 64'(dispatch), 64'd1);
        chk("stv_rel_pop", 64'(fl_pop), 64'd2);
        chk("stv_rel_ready", 64'(in_ready), 64'd1);
        tick();

        // resource thresholds: n_val = 2, n_dst = 1
        load(mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h400), mk(5'd4, 5'd5, 5'd0, 1'b1, 1'b1, 32'h404), '0, '0);
        rob_space = 5'd1;
        #1 chk("thr_rob1", 64'(dispatch), 64'd0);
        rob_space = 5'd2; rs_space = 3'd1;
        #1 chk("thr_rs1", 64'(dispatch), 64'd0);
        rs_space = 3'd2; fl_avail = 7'd0;
        #1 chk("thr_fl0", 64'(dispatch), 64'd0);
        fl_avail = 7'd1;
        #1 chk("thr_exact", 64'(dispatch), 64'd1);
        chk("thr_fl_pop", 64'(fl_pop), 64'd1);
        tick();
        fl_avail = 7'd64; rob_space = 5'd16; rs_space = 3'd4;

        // two writers of x9, slot2 reads x9
        for (int i = 0; i < 4; i++) begin
            fl_regs[i]     = 6'(50 + i);
            rob_id_next[i] = 4'(4 + i);
        end
        load(mk(5'd1, 5'd2, 5'd9, 1'b1, 1'b1, 32'h500), mk(5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 32'h504),
             mk(5'd9, 5'd9, 5'd10, 1'b1, 1'b1, 32'h508), '0);
        chk("waw_s2_rs1", 64'(rs_entries[2].rs1_paddr), 64'd51);
        chk("waw_s2_rs2", 64'(rs_entries[2].rs2_paddr), 64'd51);
        chk("waw_s2_rob1", 64'(rs_entries[2].rs1_rob), 64'd5);
        chk("waw_s2_robid", 64'(rs_entries[2].rob_id), 64'd6);
        chk("waw_dest", 64'(rat_dest), {40'd0, 6'd0, 6'd52, 6'd51, 6'd50});
        chk("waw_rat_we", 64'(rat_we), 64'b0111);
        chk("waw_isa_rd1", 64'(isa_rd[1]), 64'd9);
        chk("waw_fl_pop", 64'(fl_pop), 64'd3);
        chk("waw_s3_valid", 64'(rs_entries[3].rvfi.valid), 64'd0);
        tick();

        // flush while stalled with a new bundle waiting
        fl_avail = 7'd0;
        load(mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h600), mk(5'd1, 5'd1, 5'd4, 1'b1, 1'b1, 32'h604), '0, '0);
        in_valid = 1'b1;
        tick();
        flush = 1'b1;
        #1;
        chk("fl_stall", 64'(stall_cycles), 64'd4);
        chk("fl_dispatch", 64'(dispatch), 64'd0);
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_after_ready", 64'(in_ready), 64'd1);
        chk("fl_after_disp", 64'(dispatch), 64'd0);
        chk("fl_after_stall", 64'(stall_cycles), 64'd4);

        // reset mid-stall discards the held bundle
        load(mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'h700), '0, '0, '0);
        tick();
        chk("rs_pre_stall", 64'(stall_cycles), 64'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0; fl_avail = 7'd64;
        #1;
        chk("rs_stall", 64'(stall_cycles), 64'd0);
        chk("rs_fl_pop", 64'(fl_pop), 64'd0);
        chk("rs_in_ready", 64'(in_ready), 64'd1);
        chk("rs_dispatch", 64'(dispatch), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 The module SHALL take parameters SS (default 2, dispatch width), PR_ENTRIES (default 64, physical registers) and ROB_DEPTH (default 16, ROB entries), with PRW = clog2(PR_ENTRIES) and ROBW = clog2(ROB_DEPTH).
REQ-002 Reset SHALL be rst, synchronous, active-high; the clock SHALL be clk.
REQ-003 Ports, in order:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill the held bundle (mispredict)
in_valid  in  1  instruction queue has a bundle
in_ready  out  1  bundle accepted this cycle (queue pop)
in_inst  in  SS x instruction_info_reg_t  decoded bundle (per-slot valid, rs1/rs2/rd, needed bits, pc)
isa_rs1, isa_rs2, isa_rd  out  SS x 5  RAT lookup/update addresses
rat_rs1, rat_rs2  in  SS x PRW  RAT mappings
rat_we  out  SS x 1  RAT write enable per slot
rat_dest  out  SS x PRW  new mapping per slot
fl_avail  in  clog2(PR_ENTRIES)+1  free-list occupancy
fl_regs  in  SS x PRW  next SS free registers, in order
fl_pop  out  clog2(SS)+1  free registers consumed
pr_rs1, pr_rs2  in  SS x physical_reg_data_t  dependency/ROB_ID for the mapped sources
rob_space  in  ROBW+1  free ROB entries
rob_id_next  in  SS x ROBW  next ROB ids, in order
rs_space  in  clog2(SS)+1 minimum  free RS slots
dispatch  out  1  bundle written to RS/ROB this cycle
rs_entries  out  SS x dispatch_reservation_t  dispatched entries
stall_cycles  out  32  saturating count of cycles a held bundle waits

Function
REQ-004 A one-entry holding register (hold_valid, hold_inst) SHALL capture in_inst on the clk edge when in_valid && in_ready.
REQ-005 in_ready SHALL equal ~hold_valid || dispatch, combinationally; flush SHALL force in_ready = 0 in that cycle.
REQ-006 Let n_dst be the number of valid held slots with rd_s != 0, and n_val the number of valid held slots; dispatch SHALL equal hold_valid && ~flush && fl_avail >= n_dst && rob_space >= n_val && rs_space >= n_val.
REQ-007 Destination allocation SHALL be compacted: the k-th slot (slot order) with rd_s != 0 SHALL receive fl_regs[k]; fl_pop SHALL be n_dst when dispatch, else 0.
REQ-008 Slots with rd_s = 0 or invalid SHALL drive rat_we = 0 and rat.rd = 0; rat_we[i] SHALL be 1 only when dispatch, slot valid and rd_s != 0.
REQ-009 ROB ids SHALL also be compacted: the k-th valid slot SHALL take rob_id_next[k].
REQ-010 Intra-bundle bypass: for slot j, a source equal to rd_s of the highest-indexed earlier valid slot i < j with rd_s != 0 SHALL use slot i's new physical register and slot i's ROB id, with inputX_met = 0; otherwise it SHALL use rat_rsX[j] and pr_rsX[j].
REQ-011 Where two earlier slots write the same rd, only the youngest writer SHALL feed later sources; RAT writes SHALL resolve with the highest slot winning.
REQ-012 inputX_met SHALL be 1 when the source is not needed, or when the source is x0, else ~dependency (or 0 if bypassed).
REQ-013 rs_entries SHALL be filled from the held bundle (rvfi pc/inst/addr fields; data fields don't-care) with rvfi.valid = slot valid && dispatch; invalid slots SHALL carry rvfi.valid = 0.
REQ-014 When dispatch is 0, rat_we, fl_pop and all rvfi.valid SHALL be 0.
REQ-015 flush SHALL clear hold_valid at the next edge, overriding a simultaneous capture.
REQ-016 stall_cycles SHALL increment each cycle hold_valid && ~dispatch && ~flush and saturate at all ones.

Reset
REQ-017 On rst, hold_valid SHALL be 0 and stall_cycles 0, so in_ready = 1, dispatch = 0, fl_pop = 0 and rat_we = 0 in the following cycle; rst mid-stall SHALL discard the held bundle.

Structure
REQ-018 instruction_info_reg_t, dispatch_reservation_t and physical_reg_data_t SHALL stay in rv32i_types; no new constants go in the package.
REQ-019 Compaction (prefix count over a per-slot mask) SHALL be a sub-module prefix_alloc, instantiated twice (destinations and ROB ids).

Verification
REQ-020 Bundle {add x5,x1,x2; add x6,x5,x5}, empty RAT deps, fl_regs {40,41} -> slot1 rs1/rs2 = 40, input1_met = input2_met = 0, fl_pop = 2, rat_dest {40,41}.
REQ-021 Bundle {sw; addi x7,...}, fl_regs {33,34} -> slot1 rd = 33, slot0 rat_we = 0, fl_pop = 1.
REQ-022 fl_avail = 1 with n_dst = 2 for 3 cycles, then 2 -> dispatch = 0 for 3 cycles, in_ready = 0, stall_cycles = 3, then dispatch = 1.
REQ-023 Both slots write x9; slot 2 of SS = 4 reads x9 -> it takes slot1's register; RAT final x9 = slot1's register.
REQ-024 flush while a stall is held and in_valid = 1 -> no dispatch, next cycle hold_valid = 0, in_ready = 1.
REQ-025 rst asserted mid-stall -> next cycle stall_cycles = 0, fl_pop = 0, in_ready = 1.
